// File: rtl/aes_cozucu.sv
// ---------------------------------------------------------------------------
// aes_cozucu -- iterative AES-128 decryption core.
//
// The key is expanded forward to the last round key (K10). The inverse rounds
// then run one per cycle while the key schedule is stepped backwards, so only
// one round key is ever stored. The K10 of the most recently expanded key can
// be cached so that a block under the same key skips the forward expansion.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous reset, active low
//   anahtar    128-bit cipher key (byte 0 in the MSBs)
//   sifre      128-bit ciphertext block (byte 0 in the MSBs)
//   g_gecerli  input valid; taken on an edge where hazir is also 1
//   hazir      core idle and able to accept a block
//   blok       recovered plaintext, held until the next result
//   c_gecerli  one-cycle pulse marking a new value on blok
//
// Latency from the accept edge to the c_gecerli edge: 20 edges on a key miss,
// 10 edges on a cache hit.
// ---------------------------------------------------------------------------
module aes_cozucu #(
    parameter int ANAHTAR_ONBELLEK = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] sifre,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] blok,
    output logic         c_gecerli
);

    typedef enum logic [1:0] {BOS, ANAHTAR, TUR, SON} durum_t;

    durum_t       r_state;
    logic [127:0] r_anahtar;
    logic [127:0] r_sifre;
    logic [127:0] r_key;        // current round key of the schedule
    logic [127:0] r_durum;      // cipher state
    logic [3:0]   r_tur;        // round index
    logic [127:0] r_cache_key;
    logic [127:0] r_cache_k10;
    logic         r_cache_valid;
    logic         r_hazir;
    logic [127:0] r_blok;
    logic         r_c_gecerli;

    assign hazir     = r_hazir;
    assign blok      = r_blok;
    assign c_gecerli = r_c_gecerli;

    // -----------------------------------------------------------------------
    // Byte-level helpers
    // -----------------------------------------------------------------------
    // Forward S-box: the high nibble picks a 16-byte row, the low nibble the
    // byte within it (byte 0 of the row sits in the MSBs).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        row = '0;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
            default: row = '0;
        endcase
        return row[{~x[3:0], 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [127:0] row;
        row = '0;
        case (x[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row = 128'h172b047eba77d626e169146355210c7d;
            default: row = '0;
        endcase
        return row[{~x[3:0], 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (covers 09, 0b, 0d, 0e).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^
               (m[1] ? x2 : 8'h00) ^ (m[0] ? b  : 8'h00);
    endfunction

    // SubWord(RotWord(w))
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // -----------------------------------------------------------------------
    // Key schedule: forward step uses Rcon[r_tur], backward step Rcon[r_tur+1]
    // so that in SON (r_tur = 0) the backward step lands on K0.
    // -----------------------------------------------------------------------
    logic [7:0]  w_rcon_fwd;
    logic [7:0]  w_rcon_bwd;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;
    logic [31:0] w_p0, w_p1, w_p2, w_p3;
    logic [127:0] w_key_next;
    logic [127:0] w_key_prev;

    assign w_rcon_fwd = rcon(r_tur);
    assign w_rcon_bwd = rcon(r_tur + 4'd1);

    assign w_n0 = r_key[127:96] ^ sub_rot(r_key[31:0]) ^ {w_rcon_fwd, 24'h0};
    assign w_n1 = r_key[95:64] ^ w_n0;
    assign w_n2 = r_key[63:32] ^ w_n1;
    assign w_n3 = r_key[31:0]  ^ w_n2;
    assign w_key_next = {w_n0, w_n1, w_n2, w_n3};

    assign w_p3 = r_key[63:32]  ^ r_key[31:0];
    assign w_p2 = r_key[95:64]  ^ r_key[63:32];
    assign w_p1 = r_key[127:96] ^ r_key[95:64];
    assign w_p0 = r_key[127:96] ^ sub_rot(w_p3) ^ {w_rcon_bwd, 24'h0};
    assign w_key_prev = {w_p0, w_p1, w_p2, w_p3};

    // -----------------------------------------------------------------------
    // Data path: InvShiftRows + InvSubBytes, AddRoundKey, InvMixColumns.
    // Byte b = 4*column + row; InvShiftRows moves row r right by r columns.
    // -----------------------------------------------------------------------
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_isr
            localparam int R = gi % 4;
            localparam int C = gi / 4;
            localparam int S = 4 * ((C - R + 4) % 4) + R;
            assign w_isb[127-8*gi -: 8] = inv_sbox(r_durum[127-8*S -: 8]);
        end
    endgenerate

    assign w_ark = w_isb ^ w_key_prev;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_imc
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_ark[127-32*gi -: 8];
            assign w_a1 = w_ark[119-32*gi -: 8];
            assign w_a2 = w_ark[111-32*gi -: 8];
            assign w_a3 = w_ark[103-32*gi -: 8];
            assign w_imc[127-32*gi -: 32] = {
                gmul(w_a0, 4'he) ^ gmul(w_a1, 4'hb) ^ gmul(w_a2, 4'hd) ^ gmul(w_a3, 4'h9),
                gmul(w_a0, 4'h9) ^ gmul(w_a1, 4'he) ^ gmul(w_a2, 4'hb) ^ gmul(w_a3, 4'hd),
                gmul(w_a0, 4'hd) ^ gmul(w_a1, 4'h9) ^ gmul(w_a2, 4'he) ^ gmul(w_a3, 4'hb),
                gmul(w_a0, 4'hb) ^ gmul(w_a1, 4'hd) ^ gmul(w_a2, 4'h9) ^ gmul(w_a3, 4'he)
            };
        end
    endgenerate

    logic w_hit;
    assign w_hit = (ANAHTAR_ONBELLEK != 0) && r_cache_valid && (anahtar == r_cache_key);

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= BOS;
            r_anahtar     <= '0;
            r_sifre       <= '0;
            r_key         <= '0;
            r_durum       <= '0;
            r_tur         <= '0;
            r_cache_key   <= '0;
            r_cache_k10   <= '0;
            r_cache_valid <= 1'b0;
            r_hazir       <= 1'b1;
            r_blok        <= '0;
            r_c_gecerli   <= 1'b0;
        end else begin
            r_c_gecerli <= 1'b0;
            case (r_state)
                BOS: begin
                    if (g_gecerli && r_hazir) begin
                        r_anahtar <= anahtar;
                        r_sifre   <= sifre;
                        r_hazir   <= 1'b0;
                        if (w_hit) begin
                            r_durum <= sifre ^ r_cache_k10;
                            r_key   <= r_cache_k10;
                            r_tur   <= 4'd9;
                            r_state <= TUR;
                        end else begin
                            r_key   <= anahtar;
                            r_tur   <= 4'd1;
                            r_state <= ANAHTAR;
                        end
                    end
                end
                ANAHTAR: begin
                    r_key <= w_key_next;
                    if (r_tur == 4'd10) begin
                        r_durum       <= r_sifre ^ w_key_next;
                        r_cache_key   <= r_anahtar;
                        r_cache_k10   <= w_key_next;
                        r_cache_valid <= 1'b1;
                        r_tur         <= 4'd9;
                        r_state       <= TUR;
                    end else begin
                        r_tur <= r_tur + 4'd1;
                    end
                end
                TUR: begin
                    r_durum <= w_imc;
                    r_key   <= w_key_prev;
                    if (r_tur == 4'd1) begin
                        r_tur   <= 4'd0;
                        r_state <= SON;
                    end else begin
                        r_tur <= r_tur - 4'd1;
                    end
                end
                SON: begin
                    r_blok      <= w_ark;
                    r_c_gecerli <= 1'b1;
                    r_hazir     <= 1'b1;
                    r_state     <= BOS;
                end
                default: r_state <= BOS;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cozucu.sv
module tb_aes_cozucu;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] anahtar = '0;
    logic [127:0] sifre = '0;
    logic         g_gecerli = 1'b0;
    logic         g_gecerli_nc = 1'b0;
    logic         hazir, c_gecerli, hazir_nc, c_gecerli_nc;
    logic [127:0] blok, blok_nc;

    always #5 clk = ~clk;

    aes_cozucu #(.ANAHTAR_ONBELLEK(1)) dut (
        .clk(clk), .rst(rst), .anahtar(anahtar), .sifre(sifre),
        .g_gecerli(g_gecerli), .hazir(hazir), .blok(blok), .c_gecerli(c_gecerli)
    );

    aes_cozucu #(.ANAHTAR_ONBELLEK(0)) dut_nc (
        .clk(clk), .rst(rst), .anahtar(anahtar), .sifre(sifre),
        .g_gecerli(g_gecerli_nc), .hazir(hazir_nc), .blok(blok_nc), .c_gecerli(c_gecerli_nc)
    );

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KT  = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] CT  = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] PT  = 128'h54776f204f6e65204e696e652054776f;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int pulses_nc = 0;
    logic [127:0] sb[$];

    always @(negedge clk) begin
        if (c_gecerli === 1'b1) pulses++;
        if (c_gecerli_nc === 1'b1) pulses_nc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One block on dut (nc=0) or dut_nc (nc=1); optional disturbance while busy.
    task automatic run(input bit nc, input logic [127:0] k, input logic [127:0] ct,
                       input logic [127:0] pt, input int lat, input bit disturb,
                       input string tag);
        int n;
        int edges;
        int p0;
        bit seen;
        bit hz_ok;
        logic [127:0] expv;
        logic [127:0] obs;
        n = 0;
        while ((nc ? hazir_nc : hazir) !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk_int({tag, "_ready"}, int'(nc ? hazir_nc : hazir), 1);
        p0 = nc ? pulses_nc : pulses;
        anahtar = k;
        sifre = ct;
        if (nc) g_gecerli_nc = 1'b1; else g_gecerli = 1'b1;
        step();
        g_gecerli = 1'b0;
        g_gecerli_nc = 1'b0;
        sb.push_back(pt);
        chk_int({tag, "_busy"}, int'(nc ? hazir_nc : hazir), 0);
        edges = 0;
        seen = 1'b0;
        hz_ok = 1'b1;
        while (!seen && edges < 40) begin
            step();
            edges++;
            if ((nc ? c_gecerli_nc : c_gecerli) === 1'b1) begin
                seen = 1'b1;
            end else begin
                if ((nc ? hazir_nc : hazir) !== 1'b0) hz_ok = 1'b0;
                if (disturb) begin
                    anahtar = {4{$urandom()}};
                    sifre = {4{$urandom()}};
                    g_gecerli = edges[0];
                end
            end
        end
        g_gecerli = 1'b0;
        chk_int({tag, "_latency"}, edges, lat);
        chk_int({tag, "_hazir_low"}, int'(hz_ok), 1);
        expv = (sb.size() > 0) ? sb.pop_front() : 128'hx;
        obs = nc ? blok_nc : blok;
        chk({tag, "_blok"}, obs, expv);
        $display("txn %s: latency=%0d blok=%h", tag, edges, obs);
        step();
        chk_int({tag, "_pulse_width"}, int'(nc ? c_gecerli_nc : c_gecerli), 0);
        chk_int({tag, "_pulse_count"}, (nc ? pulses_nc : pulses) - p0, 1);
    endtask

    initial begin
        int p0;
        int edges;
        int first;
        int second;

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        chk_int("reset_hazir", int'(hazir), 1);
        chk_int("reset_c_gecerli", int'(c_gecerli), 0);
        chk("reset_blok", blok, 128'h0);
        chk_int("reset_hazir_nc", int'(hazir_nc), 1);
        rst = 1'b1;
        step();

        run(1'b0, KB, CB, PB, 20, 1'b0, "appB_miss");
        run(1'b0, KC, CC, PC, 20, 1'b0, "appC1_miss");
        run(1'b0, KC, CC, PC, 10, 1'b0, "appC1_hit");
        run(1'b0, KT, CT, PT, 20, 1'b0, "keychange_miss");
        run(1'b0, KB, CB, PB, 20, 1'b1, "busy_disturb");
        run(1'b0, KB, CB, PB, 10, 1'b0, "appB_hit");
        run(1'b0, KC, CC, PC, 20, 1'b0, "appC1_remiss");

        // Reset at edge 7 of the expansion of a new key
        p0 = pulses;
        anahtar = KT;
        sifre = CT;
        g_gecerli = 1'b1;
        step();
        g_gecerli = 1'b0;
        repeat (6) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_int("abort_hazir", int'(hazir), 1);
        chk_int("abort_c_gecerli", int'(c_gecerli), 0);
        chk("abort_blok", blok, 128'h0);
        repeat (25) step();
        chk_int("abort_no_pulse", pulses - p0, 0);
        $display("txn abort: hazir=%0d blok=%h", hazir, blok);

        run(1'b0, KC, CC, PC, 20, 1'b0, "after_reset_miss");
        run(1'b0, KC, CC, PC, 10, 1'b0, "after_reset_hit");

        // Cache disabled instance: every block expands
        run(1'b1, KC, CC, PC, 20, 1'b0, "nocache_first");
        run(1'b1, KC, CC, PC, 20, 1'b0, "nocache_repeat");

        // g_gecerli held high: hit block, then the recaptured inputs (new key)
        sb.push_back(PC);
        sb.push_back(PB);
        anahtar = KC;
        sifre = CC;
        g_gecerli = 1'b1;
        step();
        anahtar = KB;
        sifre = CB;
        edges = 0;
        first = -1;
        second = -1;
        while (second < 0 && edges < 60) begin
            step();
            edges++;
            if (c_gecerli === 1'b1) begin
                if (first < 0) begin
                    first = edges;
                    chk("hold_first_blok", blok, sb.pop_front());
                    $display("txn hold_first: edge=%0d blok=%h", edges, blok);
                end else begin
                    second = edges;
                    g_gecerli = 1'b0;
                    chk("hold_second_blok", blok, sb.pop_front());
                    $display("txn hold_second: edge=%0d blok=%h", edges, blok);
                end
            end
        end
        g_gecerli = 1'b0;
        chk_int("hold_first_edge", first, 10);
        chk_int("hold_second_edge", second, 31);
        repeat (3) step();
        chk_int("hold_idle_hazir", int'(hazir), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
